// File: rtl/errors_reporter_pkg.sv
// Shared types and constants for the error reporting path.
package errors_reporter_pkg;

   localparam int unsigned CLR_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REPORT,
      ST_DONE,
      ST_CLEAR
   } state_t;

   // Record index width; a one-bit vector still needs a one-bit index.
   function automatic int unsigned idx_width(input int unsigned bits);
      return (bits <= 1) ? 1 : $clog2(bits);
   endfunction

endpackage

// File: rtl/errors_reporter_finder.sv
// Combinational lowest-set-bit finder for the pending error vector.
module lowest_set_finder #(
   parameter int unsigned BITS  = 1,
   parameter int unsigned IDX_W = 1
) (
   input  logic [BITS-1:0]  i_vec,
   output logic [IDX_W-1:0] o_index,
   output logic             o_any
);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      o_index = '0;
      for (int i = int'(BITS) - 1; i >= 0; i--) begin
         if (i_vec[i]) o_index = IDX_W'(i);
      end
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/errors_reporter.sv
// Snapshots a locked error vector, streams one record per set bit, then
// pulses the locker clear and waits for the vector to drop before re-arming.
module errors_reporter
   import errors_reporter_pkg::*;
#(
   parameter int unsigned BITS       = 1,
   parameter int unsigned TS_W       = 32,
   parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF,
   parameter int unsigned IDX_W      = idx_width(BITS)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [BITS-1:0]  i_errors,
   input  logic             i_clear_req,
   output logic             o_rec_valid,
   input  logic             i_rec_ready,
   output logic [IDX_W-1:0] o_rec_index,
   output logic [TS_W-1:0]  o_rec_ts,
   output logic             o_rec_last,
   output logic             o_locker_clr,
   output logic             o_busy,
   output logic [15:0]      o_episodes
);

   localparam int unsigned TMR_W = (CLR_CYCLES <= 1) ? 1 : $clog2(CLR_CYCLES);

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [TS_W-1:0]  ts;
      logic             last;
   } rec_t;

   state_t           r_state;
   rec_t             r_rec;
   logic             r_valid;
   logic             r_locker_clr;
   logic             r_busy;
   logic             r_clear_pend;
   logic [15:0]      r_episodes;
   logic [TS_W-1:0]  r_ts_cnt;
   logic [BITS-1:0]  r_pending;
   logic [TMR_W-1:0] r_tmr;

   logic             w_hs;
   logic [BITS-1:0]  w_pend_nxt;
   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic             w_single;

   assign w_hs = r_valid & i_rec_ready;

   // Pending vector as it will be after this cycle; drives the next record fields.
   always_comb begin
      w_pend_nxt = r_pending;
      if (r_state == ST_IDLE) begin
         w_pend_nxt = i_errors;
      end else if (r_state == ST_REPORT && w_hs) begin
         w_pend_nxt = r_pending & ~(BITS'(1) << r_rec.index);
      end
      w_single = w_any && ((w_pend_nxt & (w_pend_nxt - BITS'(1))) == '0);
   end

   lowest_set_finder #(
      .BITS  (BITS),
      .IDX_W (IDX_W)
   ) u_finder (
      .i_vec   (w_pend_nxt),
      .o_index (w_idx),
      .o_any   (w_any)
   );

   // Capture, report, clear FSM with timestamp counter and registered outputs.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_state      <= ST_IDLE;
         r_rec        <= '0;
         r_valid      <= 1'b0;
         r_locker_clr <= 1'b0;
         r_busy       <= 1'b0;
         r_clear_pend <= 1'b0;
         r_episodes   <= '0;
         r_ts_cnt     <= '0;
         r_pending    <= '0;
         r_tmr        <= '0;
      end else begin
         r_ts_cnt <= r_ts_cnt + TS_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_pending   <= w_pend_nxt;
                  r_rec.ts    <= r_ts_cnt;
                  r_rec.index <= w_idx;
                  r_rec.last  <= w_single;
                  r_valid     <= 1'b1;
                  r_busy      <= 1'b1;
                  if (r_episodes != 16'hFFFF) r_episodes <= r_episodes + 16'd1;
                  r_state     <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (i_clear_req) r_clear_pend <= 1'b1;
               if (w_hs) begin
                  r_pending <= w_pend_nxt;
                  if (r_rec.last) begin
                     r_valid <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_rec.index <= w_idx;
                     r_rec.last  <= w_single;
                  end
               end
            end
            ST_DONE: begin
               if (i_clear_req || r_clear_pend) begin
                  r_clear_pend <= 1'b0;
                  r_locker_clr <= 1'b1;
                  r_tmr        <= TMR_W'(CLR_CYCLES - 1);
                  r_state      <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (r_locker_clr) begin
                  if (r_tmr == '0) r_locker_clr <= 1'b0;
                  else             r_tmr        <= r_tmr - TMR_W'(1);
               end else if (i_errors == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_rec_valid  = r_valid;
   assign o_rec_index  = r_rec.index;
   assign o_rec_ts     = r_rec.ts;
   assign o_rec_last   = r_rec.last;
   assign o_locker_clr = r_locker_clr;
   assign o_busy       = r_busy;
   assign o_episodes   = r_episodes;

endmodule

// File: tb/tb_errors_reporter.sv
// Directed bench for errors_reporter: capture, backpressure, clear, reset, wrap.
module tb_errors_reporter;

   localparam int unsigned BITS  = 8;
   localparam int unsigned TS_W  = 8;
   localparam int unsigned NCLR  = 4;
   localparam int unsigned IDX_W = 3;

   logic             clk = 1'b0;
   logic             srst;
   logic [BITS-1:0]  i_errors;
   logic             i_clear_req;
   logic             i_rec_ready;
   logic             o_rec_valid;
   logic [IDX_W-1:0] o_rec_index;
   logic [TS_W-1:0]  o_rec_ts;
   logic             o_rec_last;
   logic             o_locker_clr;
   logic             o_busy;
   logic [15:0]      o_episodes;

   int               n_tot = 0;
   int               n_bad = 0;
   int               ep    = 0;
   int               n;
   logic [TS_W-1:0]  tb_cnt;
   logic [TS_W-1:0]  exp_ts;

   errors_reporter #(
      .BITS       (BITS),
      .TS_W       (TS_W),
      .CLR_CYCLES (NCLR)
   ) dut (
      .clk          (clk),
      .srst         (srst),
      .i_errors     (i_errors),
      .i_clear_req  (i_clear_req),
      .o_rec_valid  (o_rec_valid),
      .i_rec_ready  (i_rec_ready),
      .o_rec_index  (o_rec_index),
      .o_rec_ts     (o_rec_ts),
      .o_rec_last   (o_rec_last),
      .o_locker_clr (o_locker_clr),
      .o_busy       (o_busy),
      .o_episodes   (o_episodes)
   );

   always #5 clk = ~clk;

   // Reference free-running timestamp.
   always @(posedge clk) begin
      if (srst) tb_cnt <= '0;
      else      tb_cnt <= tb_cnt + TS_W'(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_cnt(input logic [TS_W-1:0] v);
      int k;
      k = 0;
      while (tb_cnt != v && k < 300) begin
         tick();
         k++;
      end
      check_eq("wait_cnt", 32'(tb_cnt), 32'(v));
   endtask

   // Checks the record presented now, then advances one cycle.
   task automatic expect_rec(input string tag, input int idx, input logic [TS_W-1:0] ts, input logic last);
      check_eq({tag, "_vld"},  32'(o_rec_valid), 32'd1);
      check_eq({tag, "_idx"},  32'(o_rec_index), 32'(idx));
      check_eq({tag, "_ts"},   32'(o_rec_ts),    32'(ts));
      check_eq({tag, "_last"}, 32'(o_rec_last),  32'(last));
      tick();
   endtask

   // Waits for the clear pulse and returns its length in cycles.
   task automatic count_clr(output int cnt);
      int k;
      k = 0;
      while (!o_locker_clr && k < 10) begin
         tick();
         k++;
      end
      cnt = 0;
      while (o_locker_clr && cnt < 20) begin
         cnt++;
         tick();
      end
   endtask

   // Pulse is over: busy holds while errors stay set, drops once they clear.
   task automatic finish_clear(input string tag);
      check_eq({tag, "_hold"}, 32'(o_busy), 32'd1);
      i_errors = '0;
      tick();
      tick();
      check_eq({tag, "_idle"}, 32'(o_busy), 32'd0);
   endtask

   task automatic pulse_req();
      i_clear_req = 1'b1;
      tick();
      i_clear_req = 1'b0;
   endtask

   initial begin
      srst        = 1'b1;
      i_errors    = '0;
      i_clear_req = 1'b0;
      i_rec_ready = 1'b1;
      repeat (3) tick();
      check_eq("rst_vld",  32'(o_rec_valid),  32'd0);
      check_eq("rst_clr",  32'(o_locker_clr), 32'd0);
      check_eq("rst_busy", 32'(o_busy),       32'd0);
      check_eq("rst_ep",   32'(o_episodes),   32'd0);
      srst = 1'b0;

      // 1: capture 0x24 at counter 100, two records.
      wait_cnt(8'd100);
      i_errors = 8'h24;
      tick();
      ep++;
      check_eq("t1_busy", 32'(o_busy), 32'd1);
      check_eq("t1_ep", 32'(o_episodes), 32'(ep));
      expect_rec("t1_r0", 2, 8'd100, 1'b0);
      expect_rec("t1_r1", 5, 8'd100, 1'b1);
      check_eq("t1_done_vld", 32'(o_rec_valid), 32'd0);
      pulse_req();
      count_clr(n);
      check_eq("t1_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t1");
      pulse_req();
      tick();
      check_eq("idle_req_clr", 32'(o_locker_clr), 32'd0);
      check_eq("idle_req_busy", 32'(o_busy), 32'd0);

      // 2: backpressure for 5 cycles; input changes ignored.
      i_rec_ready = 1'b0;
      exp_ts = tb_cnt;
      i_errors = 8'h24;
      tick();
      ep++;
      i_errors = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         check_eq("t2_hold_vld",  32'(o_rec_valid), 32'd1);
         check_eq("t2_hold_idx",  32'(o_rec_index), 32'd2);
         check_eq("t2_hold_ts",   32'(o_rec_ts),    32'(exp_ts));
         check_eq("t2_hold_last", 32'(o_rec_last),  32'd0);
         tick();
      end
      i_rec_ready = 1'b1;
      expect_rec("t2_r0", 2, exp_ts, 1'b0);
      expect_rec("t2_r1", 5, exp_ts, 1'b1);
      check_eq("t2_done_vld", 32'(o_rec_valid), 32'd0);
      pulse_req();
      count_clr(n);
      check_eq("t2_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t2");

      // 3: clear request while reporting.
      i_rec_ready = 1'b0;
      exp_ts = tb_cnt;
      i_errors = 8'h24;
      tick();
      ep++;
      pulse_req();
      i_rec_ready = 1'b1;
      expect_rec("t3_r0", 2, exp_ts, 1'b0);
      expect_rec("t3_r1", 5, exp_ts, 1'b1);
      check_eq("t3_done_vld", 32'(o_rec_valid), 32'd0);
      check_eq("t3_done_clr", 32'(o_locker_clr), 32'd0);
      count_clr(n);
      check_eq("t3_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t3");

      // 4: all bits set; clear request on the last handshake.
      exp_ts = tb_cnt;
      i_errors = 8'hFF;
      tick();
      ep++;
      check_eq("t4_ep", 32'(o_episodes), 32'(ep));
      for (int k = 0; k < 7; k++) expect_rec("t4_r", k, exp_ts, 1'b0);
      i_clear_req = 1'b1;
      expect_rec("t4_r7", 7, exp_ts, 1'b1);
      i_clear_req = 1'b0;
      check_eq("t4_done_vld", 32'(o_rec_valid), 32'd0);
      check_eq("t4_done_clr", 32'(o_locker_clr), 32'd0);
      count_clr(n);
      check_eq("t4_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t4");
      check_eq("t4_ep_after", 32'(o_episodes), 32'(ep));

      // 5a: reset during REPORT, then immediate re-capture from counter 0.
      i_rec_ready = 1'b0;
      i_errors = 8'h24;
      tick();
      check_eq("t5_pre_vld", 32'(o_rec_valid), 32'd1);
      srst = 1'b1;
      tick();
      ep = 0;
      check_eq("t5a_vld",  32'(o_rec_valid), 32'd0);
      check_eq("t5a_busy", 32'(o_busy),      32'd0);
      check_eq("t5a_ep",   32'(o_episodes),  32'd0);
      check_eq("t5a_idx",  32'(o_rec_index), 32'd0);
      check_eq("t5a_ts",   32'(o_rec_ts),    32'd0);
      srst = 1'b0;
      i_rec_ready = 1'b1;
      tick();
      ep++;
      check_eq("t5a_ep_new", 32'(o_episodes), 32'(ep));
      expect_rec("t5a_r0", 2, 8'd0, 1'b0);
      expect_rec("t5a_r1", 5, 8'd0, 1'b1);

      // 5b: reset during CLEAR drops the pulse.
      pulse_req();
      check_eq("t5b_clr_on", 32'(o_locker_clr), 32'd1);
      srst = 1'b1;
      i_errors = '0;
      tick();
      ep = 0;
      check_eq("t5b_clr",  32'(o_locker_clr), 32'd0);
      check_eq("t5b_busy", 32'(o_busy),       32'd0);
      check_eq("t5b_ep",   32'(o_episodes),   32'd0);
      srst = 1'b0;
      tick();
      check_eq("t5b_idle_vld", 32'(o_rec_valid), 32'd0);
      exp_ts = tb_cnt;
      i_errors = 8'h01;
      tick();
      ep++;
      expect_rec("t5b_r0", 0, exp_ts, 1'b1);
      pulse_req();
      count_clr(n);
      check_eq("t5b_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t5b");

      // 6: capture at 255, next episode sees a wrapped timestamp.
      wait_cnt(8'd255);
      i_errors = 8'h80;
      tick();
      ep++;
      expect_rec("t6_r0", 7, 8'd255, 1'b1);
      pulse_req();
      count_clr(n);
      check_eq("t6_clr_len", 32'(n), 32'(NCLR));
      finish_clear("t6");
      exp_ts = tb_cnt;
      i_errors = 8'h01;
      tick();
      ep++;
      check_eq("t6_wrap_small", 32'(o_rec_ts < 8'd50), 32'd1);
      expect_rec("t6_r1", 0, exp_ts, 1'b1);
      check_eq("t6_ep", 32'(o_episodes), 32'(ep));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
